// File: rtl/dm_arbiter_if.sv
// Data-memory port bundle: two pipeline ports, the shared RAM port and the
// hazard-control outputs of the arbiter.
interface dm_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic          p0_req;
  logic          p0_write;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic [DW-1:0] p0_rdata;
  logic          p0_rvalid;

  logic          p1_req;
  logic          p1_write;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic [DW-1:0] p1_rdata;
  logic          p1_rvalid;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  logic          stall;
  logic [15:0]   conflict_cnt;

  modport slave (
    input  p0_req, p0_write, p0_addr, p0_wdata,
    input  p1_req, p1_write, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_rdata, p0_rvalid, p1_rdata, p1_rvalid,
    output mem_addr, mem_wdata, mem_write,
    output stall, conflict_cnt
  );

  modport master (
    output p0_req, p0_write, p0_addr, p0_wdata,
    output p1_req, p1_write, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_rdata, p0_rvalid, p1_rdata, p1_rvalid,
    input  mem_addr, mem_wdata, mem_write,
    input  stall, conflict_cnt
  );
endinterface

// File: rtl/dm_arbiter.sv
// Shares one single-port synchronous RAM between the p0/p1 data-memory ports,
// serialising same-cycle conflicts in program order (p0 older than p1).
//
// state  | meaning
// IDLE   | RAM driven directly from the port inputs
// SECOND | RAM driven from the buffered p1 access; port inputs ignored
module dm_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);
  typedef enum logic {IDLE, SECOND} state_t;

  state_t        state, state_nx;
  logic          buf_write;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;

  logic          same_addr;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;
  logic          wr_c;
  logic          stall_c;
  logic          latch_buf;
  logic          issue_rd0;
  logic          issue_rd1;
  logic          fwd;

  logic          pend0, pend1, fwd1;
  logic [DW-1:0] hold0, hold1;
  logic [15:0]   cnt;

  assign same_addr = (bus.p0_addr == bus.p1_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    addr_c    = bus.p0_addr;
    wdata_c   = bus.p0_wdata;
    wr_c      = 1'b0;
    stall_c   = 1'b0;
    latch_buf = 1'b0;
    issue_rd0 = 1'b0;
    issue_rd1 = 1'b0;
    fwd       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.p0_req && bus.p1_req) begin
          if (same_addr && !bus.p0_write && !bus.p1_write) begin
            issue_rd0 = 1'b1;
            issue_rd1 = 1'b1;
          end else if (same_addr && bus.p0_write && bus.p1_write) begin
            // p0's store is dead: p1 overwrites the same word
            addr_c  = bus.p1_addr;
            wdata_c = bus.p1_wdata;
            wr_c    = 1'b1;
          end else if (same_addr && bus.p0_write) begin
            wr_c = 1'b1;
            fwd  = 1'b1;
          end else begin
            wr_c      = bus.p0_write;
            issue_rd0 = !bus.p0_write;
            latch_buf = 1'b1;
            stall_c   = 1'b1;
            state_nx  = SECOND;
          end
        end else if (bus.p0_req) begin
          wr_c      = bus.p0_write;
          issue_rd0 = !bus.p0_write;
        end else if (bus.p1_req) begin
          addr_c    = bus.p1_addr;
          wdata_c   = bus.p1_wdata;
          wr_c      = bus.p1_write;
          issue_rd1 = !bus.p1_write;
        end
      end
      SECOND: begin
        addr_c    = buf_addr;
        wdata_c   = buf_wdata;
        wr_c      = buf_write;
        issue_rd1 = !buf_write;
        state_nx  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_write <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      pend0     <= 1'b0;
      pend1     <= 1'b0;
      fwd1      <= 1'b0;
      hold0     <= '0;
      hold1     <= '0;
      cnt       <= '0;
    end else begin
      if (latch_buf) begin
        buf_write <= bus.p1_write;
        buf_addr  <= bus.p1_addr;
        buf_wdata <= bus.p1_wdata;
      end
      pend0 <= issue_rd0;
      pend1 <= issue_rd1;
      fwd1  <= fwd;
      if (pend0) hold0 <= bus.mem_rdata;
      // a forward is newer than any read returning on the same edge
      if (fwd)        hold1 <= bus.p0_wdata;
      else if (pend1) hold1 <= bus.mem_rdata;
      if (stall_c && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end

  assign bus.mem_addr     = addr_c;
  assign bus.mem_wdata    = wdata_c;
  assign bus.mem_write    = wr_c & ~rst;
  assign bus.stall        = stall_c & ~rst;
  assign bus.conflict_cnt = cnt;

  assign bus.p0_rdata  = pend0 ? bus.mem_rdata : hold0;
  assign bus.p0_rvalid = pend0;
  assign bus.p1_rdata  = pend1 ? bus.mem_rdata : hold1;
  assign bus.p1_rvalid = pend1 | fwd1;
endmodule
